// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register, one-entry output slot, jump/branch redirect, halt on HALT_INSTR.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on non-word-aligned redirect targets).
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR   = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_address,
  input  logic [31:0] instruction,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halt,
  output logic        misalign_trap
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state_r, state_n_s;
  logic [31:0] pc_r, pc_n_s;
  logic        if_valid_r, if_valid_n_s;
  logic [31:0] if_instruction_r, if_instruction_n_s;
  logic [31:0] if_pc_r, if_pc_n_s;
  logic [31:0] if_pc_plus4_r, if_pc_plus4_n_s;
  logic        halt_r, halt_n_s;
  logic        trap_r, trap_n_s;

  logic        redirect_s;
  logic        slot_free_s;
  logic        misalign_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign redirect_s   = jump | branch_taken;
  assign target_raw_s = jump ? jump_target : branch_target;
  assign slot_free_s  = ~if_valid_r | id_ready;
  assign pc_plus4_s   = pc_r + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_s   = target_raw_s;
  assign misalign_s = redirect_s & (target_raw_s[1:0] != 2'b00);
`else
  // Low bits are dropped so every redirect lands on a word boundary.
  assign target_s   = {target_raw_s[31:2], 2'b00};
  assign misalign_s = 1'b0;
`endif

  // Next-state and next-slot logic for the fetch FSM.
  always_comb begin
    state_n_s          = state_r;
    pc_n_s             = pc_r;
    if_valid_n_s       = if_valid_r;
    if_instruction_n_s = if_instruction_r;
    if_pc_n_s          = if_pc_r;
    if_pc_plus4_n_s    = if_pc_plus4_r;
    halt_n_s           = halt_r;
    trap_n_s           = trap_r;
    case (state_r)
      RUN: begin
        if (redirect_s) begin
          // Redirect beats both stall and capture; the word read this cycle is dropped.
          pc_n_s       = target_s;
          if_valid_n_s = 1'b0;
          if (misalign_s) begin
            state_n_s = TRAP;
            trap_n_s  = 1'b1;
          end else begin
            state_n_s = RUN;
          end
        end else if (slot_free_s) begin
          if_instruction_n_s = instruction;
          if_pc_n_s          = pc_r;
          if_pc_plus4_n_s    = pc_plus4_s;
          if_valid_n_s       = 1'b1;
          pc_n_s             = pc_plus4_s;
          if (instruction == HALT_INSTR) begin
            state_n_s = HALT;
            halt_n_s  = 1'b1;
          end else begin
            state_n_s = RUN;
          end
        end else begin
          pc_n_s = pc_r;
        end
      end
      HALT: begin
        if (if_valid_r && id_ready) begin
          if_valid_n_s = 1'b0;
        end else begin
          if_valid_n_s = if_valid_r;
        end
      end
      TRAP: begin
        if_valid_n_s = 1'b0;
      end
      default: begin
        state_n_s    = RUN;
        if_valid_n_s = 1'b0;
      end
    endcase
  end

  // State and output-slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= RUN;
      pc_r             <= RESET_VECTOR;
      if_valid_r       <= 1'b0;
      if_instruction_r <= NOP_INSTR;
      if_pc_r          <= 32'h0000_0000;
      if_pc_plus4_r    <= 32'h0000_0000;
      halt_r           <= 1'b0;
      trap_r           <= 1'b0;
    end else begin
      state_r          <= state_n_s;
      pc_r             <= pc_n_s;
      if_valid_r       <= if_valid_n_s;
      if_instruction_r <= if_instruction_n_s;
      if_pc_r          <= if_pc_n_s;
      if_pc_plus4_r    <= if_pc_plus4_n_s;
      halt_r           <= halt_n_s;
      trap_r           <= trap_n_s;
    end
  end

  assign instr_address  = pc_r;
  assign if_valid       = if_valid_r;
  assign if_instruction = if_instruction_r;
  assign if_pc          = if_pc_r;
  assign if_pc_plus4    = if_pc_plus4_r;
  assign halt           = halt_r;
  assign misalign_trap  = trap_r;

endmodule
